mc_datapath_param: RTL and testbench
====================================

Name: mc_datapath_param

Overview:
- Parametrised next-generation multicycle RV32 datapath: PC, IR, old-PC, register file, unified instruction/data memory, ALU-out and memory-data registers, ALU source and result muxes.
- Driven cycle by cycle by the multicycle controller FSM.
- Adds over the current datapath:
  - configurable register count, memory depth, memory wait states and reset PC;
  - byte/half/word loads and stores with sign or zero extension;
  - a request/done memory handshake, with misalignment and range checks;
  - register x0 hardwired to zero.

Parameters:
- NREGS, 32: architectural registers; 32 for RV32I, 16 for RV32E. Register index uses the low log2(NREGS) bits of the field.
- MEM_WORDS, 1024: depth of the unified memory in 32-bit words.
- MEM_LATENCY, 1: cycles from an accepted request to commit. Legal range is 1 to 15.
- RESET_PC, 0: PC value after reset.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- mem_req, input, 1: start a memory access (fetch, load or store).
- mem_write, input, 1: qualifies mem_req as a store.
- instruction_or_data, input, 1: 0 = fetch at pc into ir; 1 = data access at result.
- mem_size, input, 2: 00 = byte, 01 = half, 10 and 11 = word.
- mem_unsigned, input, 1: 1 = zero-extend subword loads; 0 = sign-extend.
- reg_write, input, 1: write result to rd = ir[11:7].
- pc_write, input, 1: pc <= result.
- result_src, input, 2: 00 = alu_out, 01 = data, 10 = alu_result, 11 = 0.
- alu_src_a, input, 2: 00 = pc, 01 = rs1, 10 = old_pc, 11 = 0.
- alu_src_b, input, 2: 00 = rs2, 01 = 4, 10 = immediate, 11 = 0.
- alu_control, input, 4: passed through to the ALU.
- zero_flag, output, 1: ALU zero flag.
- busy, output, 1: memory access in flight.
- mem_done, output, 1: one-cycle pulse when an access completes.
- misaligned, output, 1: one-cycle pulse together with mem_done when the access was misaligned.
- instr_out, output, 32: ir.
- d_pc_out, output, 32: pc.
- d_alu_result, output, 32: alu_out.

Behaviour:
- Reset, at the clk edge with reset=1:
  - pc = RESET_PC; ir, old_pc, alu_out and data = 0; all registers = 0.
  - busy, mem_done and misaligned = 0; wait counter = 0.
  - Memory contents are retained.
  - Reset during an access aborts it: no ir/data update, no store commit, no mem_done.
- Existing sub-blocks: ALU and immediate_gen are instantiated unchanged. Immediates are generated from ir.
- Register file:
  - Reads are combinational.
  - x0 reads 0; writes to x0 are dropped.
  - Register writes occur at the edge with reg_write=1. They are independent of busy.
- alu_out <= alu_result every non-reset edge. pc <= result when pc_write=1.
- Memory FSM, states IDLE and WAIT:
  - IDLE, mem_req=1 at edge E0:
    - latch addr = instruction_or_data ? result : pc, plus mem_write, mem_size, mem_unsigned, instruction_or_data, rs2 data, and old_pc candidate = pc;
    - counter = MEM_LATENCY-1; go to WAIT; busy=1.
  - WAIT, counter > 0: decrement each edge.
  - WAIT, counter = 0, at edge E(MEM_LATENCY) — the commit edge:
    - fetch: ir <= word, old_pc <= latched pc;
    - load: data <= extended value;
    - store: byte-enabled write;
    - then mem_done=1 for exactly one cycle, busy=0, return to IDLE.
  - mem_req while busy=1 is ignored. A new request in the mem_done cycle is accepted.
- Addressing:
  - Word index = addr[31:2]. Byte lane = addr[1:0].
  - Half access uses lane addr[1]*2.
  - Store data is the low byte/half of rs2, placed in the addressed lane(s); other bytes are untouched.
- Misalignment:
  - half with addr[0]=1, or word (and fetch) with addr[1:0]≠0.
  - At commit: mem_done=1, misaligned=1, no state change.
  - Fetches always use word size.
- Out of range (word index ≥ MEM_WORDS): loads and fetches return 0; stores are dropped; misaligned=0.
- Store and fetch to the same word: memory updates at commit; a later request sees the new value.

Test Plan:
- Reset with RESET_PC=0x100 → d_pc_out=0x100, instr_out=0, busy=0, x1..x31 read 0.
- MEM_LATENCY=3, mem[0]=0x00500093, fetch request at E0 → busy high for 3 cycles, ir=0x00500093 and mem_done pulse after E3, old_pc=0.
- mem[4]=0x80FF7F01, loads at addr 0x10:
  - lb → 0x00000001;
  - lb at 0x13 → 0xFFFFFF80;
  - lhu at 0x12 → 0x000080FF;
  - lh at 0x12 → 0xFFFF80FF.
- sb of rs2=0xAB at 0x21 onto mem[8]=0x11223344 → mem[8]=0x1122AB44; followed by lw at 0x20 → 0x1122AB44.
- lw at 0x22 or sh at 0x23 → mem_done and misaligned pulse together; data/memory unchanged. Access at word index MEM_WORDS → lw returns 0, misaligned=0.
- Other cases:
  - reg_write with rd=0 → x0 stays 0;
  - mem_req while busy → ignored, exactly one mem_done;
  - reset asserted mid-store → memory unchanged, busy=0 next cycle.

Source files
------------

// File: rtl/mc_datapath_param_if.sv
// mc_datapath_param_if: control/status bundle between the multicycle controller and the datapath
//   controls : mem_req, mem_write, instruction_or_data, mem_size, mem_unsigned, reg_write,
//              pc_write, result_src, alu_src_a, alu_src_b, alu_control
//   status   : zero_flag, busy, mem_done, misaligned, instr_out, d_pc_out, d_alu_result
interface mc_datapath_param_if;
  logic mem_req, mem_write, instruction_or_data, mem_unsigned, reg_write, pc_write;
  logic [1:0] mem_size, result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic zero_flag, busy, mem_done, misaligned;
  logic [31:0] instr_out, d_pc_out, d_alu_result;
  modport master (
    output mem_req, mem_write, instruction_or_data, mem_size, mem_unsigned, reg_write, pc_write,
           result_src, alu_src_a, alu_src_b, alu_control,
    input  zero_flag, busy, mem_done, misaligned, instr_out, d_pc_out, d_alu_result
  );
  modport slave (
    input  mem_req, mem_write, instruction_or_data, mem_size, mem_unsigned, reg_write, pc_write,
           result_src, alu_src_a, alu_src_b, alu_control,
    output zero_flag, busy, mem_done, misaligned, instr_out, d_pc_out, d_alu_result
  );
endinterface

// File: rtl/mc_datapath_param.sv
// mc_datapath_param: parametrised multicycle RV32 datapath with unified memory and request/done handshake
//   clk, reset : clock and synchronous active-high reset
//   bus        : mc_datapath_param_if.slave carrying controller controls and datapath status
//   alu / immediate_gen : combinational sub-blocks used by the datapath
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_control,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    case (alu_control)
      4'd1: result = a - b;
      4'd2: result = a & b;
      4'd3: result = a | b;
      4'd4: result = a ^ b;
      4'd5: result = {31'd0, $signed(a) < $signed(b)};
      4'd6: result = {31'd0, a < b};
      4'd7: result = a << b[4:0];
      4'd8: result = a >> b[4:0];
      4'd9: result = $signed(a) >>> b[4:0];
      default: result = a + b;
    endcase
  end
  assign zero = result == '0;
endmodule

module immediate_gen (
  input  logic [31:0] instr,
  output logic [31:0] imm
);
  logic [6:0] op;
  assign op = instr[6:0];
  always_comb
    imm = op == 7'b0100011 ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          op == 7'b1100011 ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          (op == 7'b0110111 || op == 7'b0010111) ? {instr[31:12], 12'd0} :
          op == 7'b1101111 ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          {{20{instr[31]}}, instr[31:20]};
endmodule

module mc_datapath_param #(
  parameter int          NREGS       = 32,
  parameter int          MEM_WORDS   = 1024,
  parameter int          MEM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input logic clk,
  input logic reset,
  mc_datapath_param_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] regs [NREGS];
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] pc, ir, old_pc, alu_out, data, imm, src_a, src_b, alu_result, result, rs1_d, rs2_d;
  logic [31:0] a_addr, a_wdata, a_pc, rd_word, ld_val, wr_data;
  logic [RW-1:0] rs1, rs2, rd;
  logic [AW-1:0] idx;
  logic [15:0] ld_half;
  logic [7:0] ld_byte;
  logic [3:0] cnt, be;
  logic [1:0] a_size;
  logic a_write, a_unsigned, a_data, done_q, mis_q, accept, commit, word, half, mis, in_range;
  assign rs1 = ir[15 +: RW];
  assign rs2 = ir[20 +: RW];
  assign rd = ir[7 +: RW];
  assign rs1_d = rs1 == '0 ? '0 : regs[rs1];
  assign rs2_d = rs2 == '0 ? '0 : regs[rs2];
  immediate_gen u_imm (.instr(ir), .imm(imm));
  alu u_alu (.a(src_a), .b(src_b), .alu_control(bus.alu_control), .result(alu_result), .zero(bus.zero_flag));
  always_comb begin
    src_a = bus.alu_src_a == 2'd0 ? pc : bus.alu_src_a == 2'd1 ? rs1_d : bus.alu_src_a == 2'd2 ? old_pc : '0;
    src_b = bus.alu_src_b == 2'd0 ? rs2_d : bus.alu_src_b == 2'd1 ? 32'd4 : bus.alu_src_b == 2'd2 ? imm : '0;
    result = bus.result_src == 2'd0 ? alu_out : bus.result_src == 2'd1 ? data :
             bus.result_src == 2'd2 ? alu_result : '0;
  end
  // Everything below the latched request decodes the access being committed.
  assign accept = state == IDLE && bus.mem_req;
  assign commit = state == WAIT && cnt == '0;
  assign word = !a_data || a_size[1];
  assign half = a_size == 2'b01;
  assign mis = word ? |a_addr[1:0] : half && a_addr[0];
  assign in_range = a_addr[31:2] < 30'(MEM_WORDS);
  assign idx = a_addr[AW+1:2];
  assign rd_word = in_range ? mem[idx] : '0;
  assign ld_byte = rd_word[{a_addr[1:0], 3'b000} +: 8];
  assign ld_half = rd_word[{a_addr[1], 4'b0000} +: 16];
  assign ld_val = word ? rd_word :
                  half ? {{16{!a_unsigned && ld_half[15]}}, ld_half} : {{24{!a_unsigned && ld_byte[7]}}, ld_byte};
  assign be = word ? 4'hF : half ? (a_addr[1] ? 4'hC : 4'h3) : 4'b0001 << a_addr[1:0];
  assign wr_data = word ? a_wdata : half ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
  always_comb begin
    state_n = state;
    state_n = accept ? WAIT : commit ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      ir <= '0;
      old_pc <= '0;
      alu_out <= '0;
      data <= '0;
      state <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      alu_out <= alu_result;
      if (bus.pc_write) pc <= result;
      state <= state_n;
      cnt <= accept ? 4'(MEM_LATENCY - 1) : cnt - {3'd0, |cnt};
      done_q <= commit;
      mis_q <= commit && mis;
      if (accept) begin
        a_addr <= bus.instruction_or_data ? result : pc;
        a_write <= bus.mem_write;
        a_size <= bus.mem_size;
        a_unsigned <= bus.mem_unsigned;
        a_data <= bus.instruction_or_data;
        a_wdata <= rs2_d;
        a_pc <= pc;
      end
      if (commit && !mis && !a_data) begin
        ir <= rd_word;
        old_pc <= a_pc;
      end
      if (commit && !mis && a_data && !a_write) data <= ld_val;
    end
  end
  always_ff @(posedge clk) begin
    if (reset)
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (bus.reg_write && rd != '0)
      regs[rd] <= result;
  end
  // Memory has no reset; a reset edge that coincides with commit drops the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && a_data && a_write && !mis && in_range)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
  end
  assign bus.busy = state == WAIT;
  assign bus.mem_done = done_q;
  assign bus.misaligned = mis_q;
  assign bus.instr_out = ir;
  assign bus.d_pc_out = pc;
  assign bus.d_alu_result = alu_out;
endmodule

// File: tb/tb_mc_datapath_param.sv
// tb_mc_datapath_param: scoreboard bench for mc_datapath_param (latency 3, 256 words, reset pc 0x100)
module tb_mc_datapath_param;
  typedef struct {
    string tag;
    logic [31:0] val;
    logic mis;
    logic dat;
    logic wr;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  mc_datapath_param_if bus();
  mc_datapath_param #(.NREGS(32), .MEM_WORDS(256), .MEM_LATENCY(3), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ld(input logic [11:0] imm);
    return {imm, 5'd0, 3'd2, 5'd0, 7'b0000011};
  endfunction
  function automatic logic [31:0] st(input logic [11:0] imm, input logic [4:0] rs2);
    return {imm[11:5], rs2, 5'd0, 3'd0, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] addi(input logic [11:0] imm, input logic [4:0] rd);
    return {imm, 5'd0, 3'd0, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] rr(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, 5'd0, 7'b0110011};
  endfunction
  task automatic cyc(input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb, input logic rw, input logic pw);
    bus.result_src = rs;
    bus.alu_src_a = sa;
    bus.alu_src_b = sb;
    bus.alu_control = 4'd0;
    bus.reg_write = rw;
    bus.pc_write = pw;
    @(posedge clk);
    @(negedge clk);
    bus.reg_write = 1'b0;
    bus.pc_write = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && !bus.mem_done; i++) @(negedge clk);
    check({tag, "_done"}, 32'(bus.mem_done), 32'd1);
  endtask
  task automatic drive_req(input logic dat, input logic wr, input logic [1:0] sz, input logic uns);
    bus.mem_req = 1'b1;
    bus.instruction_or_data = dat;
    bus.mem_write = wr;
    bus.mem_size = sz;
    bus.mem_unsigned = uns;
    bus.result_src = 2'd2;
    bus.alu_src_a = 2'd3;
    bus.alu_src_b = 2'd2;
    bus.alu_control = 4'd0;
  endtask
  task automatic access(input string tag, input logic dat, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] ev, input logic emis);
    exp_t e;
    sb_q.push_back('{tag, ev, emis, dat, wr});
    drive_req(dat, wr, sz, uns);
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    wait_done(tag);
    e = sb_q.pop_front();
    check({e.tag, "_mis"}, 32'(bus.misaligned), 32'(e.mis));
    if (!e.dat) check({e.tag, "_ir"}, bus.instr_out, e.val);
    else if (!e.wr) begin
      cyc(2'd1, 2'd0, 2'd0, 1'b0, 1'b1);
      check({e.tag, "_data"}, bus.d_pc_out, e.val);
    end
  endtask
  task automatic set_ir(input logic [31:0] w);
    cyc(2'd3, 2'd0, 2'd0, 1'b0, 1'b1);
    dut.mem[0] <= w;
    access("fetch", 1'b0, 1'b0, 2'd2, 1'b0, w, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, first, pulses;
    bus.mem_req = 1'b0;
    bus.mem_write = 1'b0;
    bus.instruction_or_data = 1'b0;
    bus.mem_size = 2'd0;
    bus.mem_unsigned = 1'b0;
    bus.reg_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.result_src = 2'd0;
    bus.alu_src_a = 2'd0;
    bus.alu_src_b = 2'd0;
    bus.alu_control = 4'd0;
    dut.mem[8'h40] <= 32'h00500093;
    dut.mem[4] <= 32'h80FF7F01;
    dut.mem[8] <= 32'h11223344;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_pc", bus.d_pc_out, 32'h100);
    check("rst_ir", bus.instr_out, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.mem_done), 32'd0);
    check("rst_mis", 32'(bus.misaligned), 32'd0);
    check("rst_aluout", bus.d_alu_result, 32'h0);
    // first fetch from the reset pc, timing observed cycle by cycle
    drive_req(1'b0, 1'b0, 2'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    n = 0;
    while (bus.busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("f0_busy_cycles", 32'(n), 32'd3);
    check("f0_done", 32'(bus.mem_done), 32'd1);
    check("f0_ir", bus.instr_out, 32'h00500093);
    @(negedge clk);
    check("f0_done_pulse", 32'(bus.mem_done), 32'd0);
    cyc(2'd0, 2'd2, 2'd3, 1'b0, 1'b0);
    check("f0_old_pc", bus.d_alu_result, 32'h100);
    // register file: x1 = 5 from the fetched addi, x31 still 0, x0 stays 0
    cyc(2'd2, 2'd3, 2'd2, 1'b1, 1'b0);
    set_ir(rr(5'd1, 5'd31));
    cyc(2'd0, 2'd1, 2'd3, 1'b0, 1'b0);
    check("x1", bus.d_alu_result, 32'd5);
    cyc(2'd0, 2'd3, 2'd0, 1'b0, 1'b0);
    check("x31", bus.d_alu_result, 32'd0);
    bus.alu_src_a = 2'd1;
    bus.alu_src_b = 2'd3;
    #1 check("zero_flag_lo", 32'(bus.zero_flag), 32'd0);
    bus.alu_src_a = 2'd3;
    #1 check("zero_flag_hi", 32'(bus.zero_flag), 32'd1);
    set_ir(addi(12'h055, 5'd0));
    cyc(2'd2, 2'd3, 2'd2, 1'b1, 1'b0);
    cyc(2'd0, 2'd1, 2'd3, 1'b0, 1'b0);
    check("x0", bus.d_alu_result, 32'd0);
    // subword loads from mem[4] = 0x80FF7F01
    set_ir(ld(12'h010));
    access("lb10", 1'b1, 1'b0, 2'd0, 1'b0, 32'h00000001, 1'b0);
    set_ir(ld(12'h013));
    access("lb13", 1'b1, 1'b0, 2'd0, 1'b0, 32'hFFFFFF80, 1'b0);
    set_ir(ld(12'h012));
    access("lhu12", 1'b1, 1'b0, 2'd1, 1'b1, 32'h000080FF, 1'b0);
    access("lh12", 1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF80FF, 1'b0);
    // stores into mem[8] = 0x11223344 with x5 = 0xAB
    set_ir(addi(12'h0AB, 5'd5));
    cyc(2'd2, 2'd3, 2'd2, 1'b1, 1'b0);
    set_ir(st(12'h021, 5'd5));
    access("sb21", 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 1'b0);
    set_ir(ld(12'h020));
    access("lw20_sb", 1'b1, 1'b0, 2'd2, 1'b0, 32'h1122AB44, 1'b0);
    set_ir(st(12'h022, 5'd5));
    access("sh22", 1'b1, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0);
    set_ir(ld(12'h020));
    access("lw20_sh", 1'b1, 1'b0, 2'd2, 1'b0, 32'h00ABAB44, 1'b0);
    // misaligned accesses change nothing
    set_ir(ld(12'h022));
    access("lw22_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h00ABAB44, 1'b1);
    set_ir(st(12'h023, 5'd5));
    access("sh23_mis", 1'b1, 1'b1, 2'd1, 1'b0, 32'h0, 1'b1);
    set_ir(ld(12'h020));
    access("lw20_after_mis", 1'b1, 1'b0, 2'd2, 1'b0, 32'h00ABAB44, 1'b0);
    // word index 256 is out of range and must not alias mem[0]
    set_ir(ld(12'h400));
    access("lw_oor", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    set_ir(st(12'h400, 5'd5));
    access("sw_oor", 1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 1'b0);
    cyc(2'd3, 2'd0, 2'd0, 1'b0, 1'b1);
    access("fetch_oor", 1'b0, 1'b0, 2'd2, 1'b0, st(12'h400, 5'd5), 1'b0);
    // requests while busy are ignored
    set_ir(ld(12'h010));
    drive_req(1'b1, 1'b0, 2'd2, 1'b0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.mem_req = 1'b0;
    first = -1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.mem_done) begin
        pulses++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    check("busy_ign_pulses", 32'(pulses), 32'd1);
    check("busy_ign_when", 32'(first), 32'd1);
    // a request in the mem_done cycle is accepted
    drive_req(1'b1, 1'b0, 2'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    wait_done("b2b_a");
    bus.mem_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b_b");
    // reset in the middle of a word store to 0x20
    set_ir(st(12'h020, 5'd5));
    drive_req(1'b1, 1'b1, 2'd2, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.mem_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pc", bus.d_pc_out, 32'h100);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_done) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    set_ir(rr(5'd5, 5'd0));
    cyc(2'd0, 2'd1, 2'd3, 1'b0, 1'b0);
    check("abort_x5", bus.d_alu_result, 32'd0);
    set_ir(ld(12'h020));
    access("lw20_abort", 1'b1, 1'b0, 2'd2, 1'b0, 32'h00ABAB44, 1'b0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
